// File: rtl/debug_cmd_sync_queue.sv
// debug_cmd_sync_queue
// System-clock side of the debug slave path. The virtual-JTAG update strobes
// (vs_udr, vs_uir) are synchronised into clk. Each rising edge captures
// {sr, ir_in} as a command entry. Entries are buffered in a small FIFO with a
// valid/ready head. Popping a DR entry emits a one-hot take_action or
// take_no_action pulse indexed by its IR code.
// Optional feature macro: DBG_CMD_TIMESTAMP_EN stamps each entry with a
// free-running 16-bit clk count. When the macro is undefined, cmd_ts reads 0.
module debug_cmd_sync_queue #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4,
    parameter int ACT_BIT     = 37
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DATA_W-1:0]          sr,
    input  logic                       vs_udr,
    input  logic                       vs_uir,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [DATA_W-1:0]          cmd_data,
    output logic [IR_W-1:0]            cmd_ir,
    output logic                       cmd_is_ir,
    output logic [15:0]                cmd_ts,
    output logic [(1<<IR_W)-1:0]       take_action,
    output logic [(1<<IR_W)-1:0]       take_no_action,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int NA = 1 << IR_W;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_hist, uir_hist;
    logic                   udr_rise, uir_rise;

    logic                   pend_vld;
    logic [DATA_W-1:0]      pend_data;
    logic [IR_W-1:0]        pend_ir;

    logic                   push_req, push_is_ir, pend_load, pend_clr, arb_drop;
    logic [DATA_W-1:0]      push_data;
    logic [IR_W-1:0]        push_ir;
    logic                   pop, push_ok, drop;

    logic [AW:0]            wptr, rptr, rptr_nxt;
    logic                   head_avail;
    logic [AW-1:0]          rd_idx;

    logic [DATA_W-1:0]      mem_data  [DEPTH];
    logic [IR_W-1:0]        mem_ir    [DEPTH];
    logic                   mem_is_ir [DEPTH];

    // Strobe synchronisers; the history flop sits after the last sync stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync <= '0;
            uir_sync <= '0;
            udr_hist <= 1'b0;
            uir_hist <= 1'b0;
        end else begin
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_hist <= udr_sync[SYNC_STAGES-1];
            uir_hist <= uir_sync[SYNC_STAGES-1];
        end
    end

    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_hist;
    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_hist;

    // One push slot per cycle: UIR first, then a deferred UDR, then a fresh UDR
    always_comb begin
        push_req   = 1'b0;
        push_is_ir = 1'b0;
        push_data  = sr;
        push_ir    = ir_in;
        pend_load  = 1'b0;
        pend_clr   = 1'b0;
        arb_drop   = 1'b0;
        if (uir_rise) begin
            push_req   = 1'b1;
            push_is_ir = 1'b1;
            if (udr_rise) begin
                if (pend_vld) arb_drop  = 1'b1;
                else          pend_load = 1'b1;
            end
        end else if (pend_vld) begin
            push_req  = 1'b1;
            push_data = pend_data;
            push_ir   = pend_ir;
            pend_clr  = 1'b1;
            if (udr_rise) arb_drop = 1'b1;
        end else if (udr_rise) begin
            push_req = 1'b1;
        end
    end

    assign pop        = cmd_valid & cmd_ready;
    assign level      = wptr - rptr;
    assign push_ok    = push_req & ((level != FULL_LVL) | pop);
    assign drop       = arb_drop | (push_req & ~push_ok);
    assign rptr_nxt   = rptr + {{AW{1'b0}}, pop};
    assign head_avail = (wptr != rptr_nxt);
    assign rd_idx     = rptr_nxt[AW-1:0];

    // Pend occupancy flag for a UDR rise that collided with a UIR rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       pend_vld <= 1'b0;
        else if (pend_load) pend_vld <= 1'b1;
        else if (pend_clr)  pend_vld <= 1'b0;
    end

    // Pend payload, captured in the cycle of the colliding rise
    always_ff @(posedge clk) begin
        if (pend_load) begin
            pend_data <= sr;
            pend_ir   <= ir_in;
        end
    end

    // FIFO pointers carry one extra wrap bit so full and empty differ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + {{AW{1'b0}}, push_ok};
            rptr <= rptr_nxt;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wptr[AW-1:0]]  <= push_data;
            mem_ir[wptr[AW-1:0]]    <= push_ir;
            mem_is_ir[wptr[AW-1:0]] <= push_is_ir;
        end
    end

    // Head register shows the oldest entry remaining after this cycle's pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            cmd_ir    <= '0;
            cmd_is_ir <= 1'b0;
        end else begin
            cmd_valid <= head_avail;
            if (head_avail) begin
                cmd_data  <= mem_data[rd_idx];
                cmd_ir    <= mem_ir[rd_idx];
                cmd_is_ir <= mem_is_ir[rd_idx];
            end
        end
    end

    // One-cycle action pulses for popped DR entries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= (pop & ~cmd_is_ir &  cmd_data[ACT_BIT]) ? (NA'(1) << cmd_ir) : '0;
            take_no_action <= (pop & ~cmd_is_ir & ~cmd_data[ACT_BIT]) ? (NA'(1) << cmd_ir) : '0;
        end
    end

    // Sticky overflow; a new drop beats a clear in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

`ifdef DBG_CMD_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] mem_ts [DEPTH];

    // Free-running timestamp counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_cnt <= '0;
        else          ts_cnt <= ts_cnt + 16'd1;
    end

    // Timestamp storage alongside each entry
    always_ff @(posedge clk) begin
        if (push_ok) mem_ts[wptr[AW-1:0]] <= ts_cnt;
    end

    // Timestamp head register, loaded together with the other head fields
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        cmd_ts <= '0;
        else if (head_avail) cmd_ts <= mem_ts[rd_idx];
    end
`else
    assign cmd_ts = 16'd0;
`endif

endmodule

// File: tb/tb_debug_cmd_sync_queue.sv
// Testbench for debug_cmd_sync_queue: directed scenarios with literal
// expectations plus randomized strobes/back-pressure against a queue model.
module tb_debug_cmd_sync_queue;

    localparam int DATA_W      = 38;
    localparam int IR_W        = 2;
    localparam int SYNC_STAGES = 2;
    localparam int DEPTH       = 4;
    localparam int ACT_BIT     = 37;
    localparam int NA          = 1 << IR_W;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [IR_W-1:0]   ir_in = '0;
    logic [DATA_W-1:0] sr = '0;
    logic              vs_udr = 1'b0;
    logic              vs_uir = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [DATA_W-1:0] cmd_data;
    logic [IR_W-1:0]   cmd_ir;
    logic              cmd_is_ir;
    logic [15:0]       cmd_ts;
    logic [NA-1:0]     take_action;
    logic [NA-1:0]     take_no_action;
    logic              overflow;
    logic              ovf_clr = 1'b0;
    logic [LW-1:0]     level;

    int checks = 0;
    int errors = 0;

    debug_cmd_sync_queue #(
        .DATA_W(DATA_W), .IR_W(IR_W), .SYNC_STAGES(SYNC_STAGES),
        .DEPTH(DEPTH), .ACT_BIT(ACT_BIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
        .vs_udr(vs_udr), .vs_uir(vs_uir),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_ir(cmd_ir), .cmd_is_ir(cmd_is_ir), .cmd_ts(cmd_ts),
        .take_action(take_action), .take_no_action(take_no_action),
        .overflow(overflow), .ovf_clr(ovf_clr), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IR_W-1:0]   ir;
        logic              is_ir;
        logic [15:0]       ts;
    } ent_t;

    ent_t              mq[$];
    ent_t              m_head, m_pend;
    logic              m_valid, m_pend_v, m_ovf;
    logic [NA-1:0]     m_ta, m_tna;
    logic [15:0]       m_cnt;
    // Recent strobe samples, index 0 = sample taken at the previous edge
    logic [SYNC_STAGES:0] m_udr_line, m_uir_line;

    task automatic model_step();
        logic pop, ur, irr, have, drop;
        ent_t cur, pe;
        if (!reset_n) begin
            mq.delete();
            m_head     = '{default: '0};
            m_pend     = '{default: '0};
            m_valid    = 1'b0;
            m_pend_v   = 1'b0;
            m_ovf      = 1'b0;
            m_ta       = '0;
            m_tna      = '0;
            m_cnt      = '0;
            m_udr_line = '0;
            m_uir_line = '0;
            return;
        end
        // A strobe edge becomes visible SYNC_STAGES edges after it is sampled
        ur  = m_udr_line[SYNC_STAGES-1] & ~m_udr_line[SYNC_STAGES];
        irr = m_uir_line[SYNC_STAGES-1] & ~m_uir_line[SYNC_STAGES];
        pop = m_valid & cmd_ready;
        m_ta  = '0;
        m_tna = '0;
        if (pop && !m_head.is_ir) begin
            if (m_head.data[ACT_BIT]) m_ta[m_head.ir]  = 1'b1;
            else                      m_tna[m_head.ir] = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        m_valid = (mq.size() > 0);
        if (m_valid) m_head = mq[0];

        cur.data = sr; cur.ir = ir_in; cur.is_ir = 1'b0; cur.ts = m_cnt;
        have = 1'b0; drop = 1'b0; pe = cur;
        if (irr) begin
            pe.is_ir = 1'b1; have = 1'b1;
            if (ur) begin
                if (m_pend_v) drop = 1'b1;
                else begin m_pend = cur; m_pend_v = 1'b1; end
            end
        end else if (m_pend_v) begin
            pe = m_pend; pe.ts = m_cnt; have = 1'b1; m_pend_v = 1'b0;
            if (ur) drop = 1'b1;
        end else if (ur) begin
            have = 1'b1;
        end
        if (have) begin
            if (mq.size() < DEPTH) mq.push_back(pe);
            else                   drop = 1'b1;
        end
        if (drop)         m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        m_cnt      = m_cnt + 16'd1;
        m_udr_line = {m_udr_line[SYNC_STAGES-1:0], vs_udr};
        m_uir_line = {m_uir_line[SYNC_STAGES-1:0], vs_uir};
    endtask

    task automatic compare();
        logic [15:0] exp_ts;
`ifdef DBG_CMD_TIMESTAMP_EN
        exp_ts = m_head.ts;
`else
        exp_ts = 16'd0;
`endif
        chk("m_cmd_valid",      64'(cmd_valid),      64'(m_valid));
        chk("m_level",          64'(level),          64'(mq.size()));
        chk("m_cmd_data",       64'(cmd_data),       64'(m_head.data));
        chk("m_cmd_ir",         64'(cmd_ir),         64'(m_head.ir));
        chk("m_cmd_is_ir",      64'(cmd_is_ir),      64'(m_head.is_ir));
        chk("m_cmd_ts",         64'(cmd_ts),         64'(exp_ts));
        chk("m_take_action",    64'(take_action),    64'(m_ta));
        chk("m_take_no_action", 64'(take_no_action), 64'(m_tna));
        chk("m_overflow",       64'(overflow),       64'(m_ovf));
    endtask

    // Model advances on each active edge; outputs are compared 1 time unit later
    always begin
        @(posedge clk);
        model_step();
        #1;
        compare();
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic udr_pulse(input logic [DATA_W-1:0] d);
        sr = d;
        vs_udr = 1'b1;
        step(2);
        vs_udr = 1'b0;
        step(2);
    endtask

    task automatic drain();
        cmd_ready = 1'b1;
        step(DEPTH + 2);
        cmd_ready = 1'b0;
    endtask

    logic [15:0] ts_a, ts_b;

    initial begin
        step(2);
        chk("rst_valid",    64'(cmd_valid),      64'd0);
        chk("rst_level",    64'(level),          64'd0);
        chk("rst_overflow", 64'(overflow),       64'd0);
        chk("rst_ta",       64'(take_action),    64'd0);
        chk("rst_data",     64'(cmd_data),       64'd0);
        reset_n = 1'b1;
        step(2);

        // 1: single UDR command with ACT bit set
        cmd_ready = 1'b1;
        ir_in = 2'b01;
        sr = 38'h2A_0000_1234;
        vs_udr = 1'b1;
        step(3);
        chk("t1_valid_e3", 64'(cmd_valid), 64'd0);
        step(1);
        chk("t1_valid_e4", 64'(cmd_valid), 64'd1);
        chk("t1_data",     64'(cmd_data),  64'h2A_0000_1234);
        chk("t1_ir",       64'(cmd_ir),    64'd1);
        step(1);
        chk("t1_ta",  64'(take_action),    64'b0010);
        chk("t1_tna", 64'(take_no_action), 64'd0);
        step(1);
        chk("t1_ta_off", 64'(take_action), 64'd0);
        vs_udr = 1'b0;
        cmd_ready = 1'b0;
        step(4);

        // 2: simultaneous UIR and UDR rises
        ir_in = 2'b10;
        sr = 38'h5;
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        step(3);
        chk("t2_level1", 64'(level), 64'd1);
        step(1);
        chk("t2_level2", 64'(level),     64'd2);
        chk("t2_is_ir",  64'(cmd_is_ir), 64'd1);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        cmd_ready = 1'b1;
        step(1);
        chk("t2_is_dr",   64'(cmd_is_ir),                   64'd0);
        chk("t2_nopulse", 64'({take_action, take_no_action}), 64'd0);
        step(1);
        chk("t2_tna",   64'(take_no_action), 64'b0100);
        chk("t2_empty", 64'(cmd_valid),      64'd0);
        cmd_ready = 1'b0;
        step(2);

        // 3: overflow on a full FIFO, then drain in order and clear
        for (int k = 1; k <= 5; k++) udr_pulse(DATA_W'(k));
        chk("t3_level", 64'(level),    64'd4);
        chk("t3_ovf",   64'(overflow), 64'd1);
        chk("t3_d1",    64'(cmd_data), 64'd1);
        cmd_ready = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            step(1);
            chk("t3_drain", 64'(cmd_data), 64'(k));
        end
        step(1);
        chk("t3_empty", 64'(cmd_valid), 64'd0);
        cmd_ready = 1'b0;
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 64'(overflow), 64'd0);

        // 4: push and pop in the same cycle while full
        for (int k = 10; k <= 13; k++) udr_pulse(DATA_W'(k));
        sr = 38'd14;
        vs_udr = 1'b1;
        step(2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        chk("t4_level", 64'(level),    64'd4);
        chk("t4_ovf",   64'(overflow), 64'd0);
        step(2);
        cmd_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            chk("t4_order", 64'(cmd_data), 64'(k));
            step(1);
        end
        cmd_ready = 1'b0;
        step(2);

        // 5: reset while entries queued and a strobe held high
        for (int k = 20; k <= 22; k++) udr_pulse(DATA_W'(k));
        sr = 38'd30;
        vs_udr = 1'b1;
        step(1);
        chk("t5_level_pre", 64'(level), 64'd3);
        reset_n = 1'b0;
        step(1);
        chk("t5_level_rst", 64'(level),                         64'd0);
        chk("t5_valid_rst", 64'(cmd_valid),                     64'd0);
        chk("t5_pulse_rst", 64'({take_action, take_no_action}), 64'd0);
        reset_n = 1'b1;
        step(6);
        chk("t5_one",  64'(level),    64'd1);
        chk("t5_data", 64'(cmd_data), 64'd30);
        vs_udr = 1'b0;
        step(5);
        chk("t5_still_one", 64'(level), 64'd1);
        drain();

        // 6: timestamps of two pushes ten cycles apart
        sr = 38'd40;
        vs_udr = 1'b1;
        step(5);
        vs_udr = 1'b0;
        step(5);
        sr = 38'd41;
        vs_udr = 1'b1;
        step(5);
        vs_udr = 1'b0;
        step(2);
        ts_a = cmd_ts;
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        ts_b = cmd_ts;
        chk("t6_second", 64'(cmd_data), 64'd41);
`ifdef DBG_CMD_TIMESTAMP_EN
        chk("t6_ts_delta", 64'(ts_b - ts_a), 64'd10);
`else
        chk("t6_ts_zero", 64'(ts_a | ts_b), 64'd0);
`endif
        drain();

        // Randomized phase
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 2) == 0) vs_udr = ~vs_udr;
            if ($urandom_range(0, 3) == 0) vs_uir = ~vs_uir;
            if (i < 300) cmd_ready = ($urandom_range(0, 3) == 0);
            else         cmd_ready = ($urandom_range(0, 1) == 0);
            sr      = DATA_W'({$urandom(), $urandom()});
            ir_in   = IR_W'($urandom());
            ovf_clr = ($urandom_range(0, 15) == 0);
            if (i == 500) reset_n = 1'b0;
            if (i == 501) reset_n = 1'b1;
            step(1);
        end
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        ovf_clr = 1'b0;
        drain();
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_cmd_sync_queue.md
Name: debug_cmd_sync_queue

Overview:
Parametrised system-clock half of the debug slave path. Synchronises the virtual-JTAG update strobes (vs_udr, vs_uir) into clk and captures the shifted register (sr) and instruction (ir_in) as command entries. Queues the entries in a small FIFO with a valid/ready interface. On each pop it issues one-hot take_action / take_no_action pulses per IR code. It succeeds the fixed 38-bit, 2-bit-IR, unbuffered sysclk decoder, adding arbitrary widths, buffering, back-pressure and overflow reporting.

Parameters:
DATA_W, 38, width of sr / cmd_data
IR_W, 2, width of ir_in / cmd_ir; action vectors are 2**IR_W wide
SYNC_STAGES, 2, synchroniser flops per strobe (min 2)
DEPTH, 4, FIFO entries (power of 2, min 2)
ACT_BIT, 37, cmd_data bit selecting take_action vs take_no_action

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ir_in  in  IR_W  virtual IR value, quasi-static (tck domain)
sr  in  DATA_W  DR shift-register contents, quasi-static at udr
vs_udr  in  1  update-DR level strobe, async
vs_uir  in  1  update-IR level strobe, async
cmd_valid  out  1  head entry available
cmd_ready  in  1  consumer accepts head entry
cmd_data  out  DATA_W  head entry data (jdo equivalent)
cmd_ir  out  IR_W  head entry IR code
cmd_is_ir  out  1  head entry came from UIR (1) or UDR (0)
cmd_ts  out  16  head entry timestamp (see Optional Feature)
take_action  out  2**IR_W  one-cycle one-hot pulse on DR pop with cmd_data[ACT_BIT]=1
take_no_action  out  2**IR_W  one-cycle one-hot pulse on DR pop with cmd_data[ACT_BIT]=0
overflow  out  1  sticky: an entry was dropped
ovf_clr  in  1  synchronous clear of overflow
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): sync chains, edge registers, pend register and pointers cleared. Outputs: cmd_valid=0, cmd_data=0, cmd_ir=0, cmd_is_ir=0, cmd_ts=0, take_action=0, take_no_action=0, overflow=0, level=0.
- Each strobe passes through SYNC_STAGES flops plus one history flop. A rise is sync_out & ~hist.
- Push on UDR rise: entry {sr, ir_in, is_ir=0} sampled at the push cycle.
- Push on UIR rise: entry {sr, ir_in, is_ir=1}.
- Both rises in the same cycle: UIR entry pushed now; UDR rise held in a 1-entry pend register and pushed the next cycle. If a new UDR rise arrives while pend is occupied, the new rise is dropped and overflow is set.
- Latency: first clk edge sampling vs_udr=1 -> cmd_valid=1 after SYNC_STAGES+2 edges on an empty FIFO (4 for default).
- Pop when cmd_valid & cmd_ready. Head outputs are registered and change the cycle after a pop. cmd_data etc. hold their value while cmd_valid=0.
- Pop with cmd_is_ir=0: in the cycle after the pop, take_action[cmd_ir] or take_no_action[cmd_ir] pulses for exactly one cycle, selected by the popped cmd_data[ACT_BIT]. Pop with cmd_is_ir=1: no pulse.
- Full (level==DEPTH):
  - A push without a simultaneous pop drops the entry and sets overflow.
  - Push and pop in the same cycle both succeed; level is unchanged.
- Empty: cmd_ready is ignored and no pulse is issued.
- Pointers wrap modulo DEPTH; level is computed from extended pointers so that full and empty are distinct.
- ovf_clr together with a new drop in the same cycle: overflow stays 1 (set wins).
- Reset mid-operation discards all queued and pending entries. A strobe still high after reset release is not treated as a rise, because the history flop resets to 0 and the chain must refill first. Such a strobe is seen as one rise after the sync latency.

Optional Feature:
DBG_CMD_TIMESTAMP_EN
- Defined: a free-running 16-bit clk counter (reset 0, wraps 0xFFFF->0) is stored with each entry at its push cycle and presented on cmd_ts with the head.
- Undefined: no counter or timestamp storage; cmd_ts tied to 0.

Test Plan:
1. DEPTH=4, IR_W=2. ir_in=2'b01, sr[37]=1, sr=0x2A_0000_1234; pulse vs_udr high for 6 clk; cmd_ready=1 -> cmd_valid rises 4 edges after first sample; cmd_data=0x2A_0000_1234, cmd_ir=1; take_action=4'b0010 for 1 cycle; take_no_action=0.
2. vs_uir and vs_udr rise on the same clk, cmd_ready=0 -> level 1 then 2; first pop cmd_is_ir=1, second cmd_is_ir=0; no pulse for the IR entry.
3. cmd_ready=0; 5 UDR strobes with sr=1..5 -> level=4, overflow=1; drain yields 1,2,3,4. ovf_clr -> overflow=0.
4. FIFO full, cmd_ready=1 and a push in the same cycle -> level stays 4, overflow stays 0, and the new entry appears last in order.
5. reset_n low for 1 cycle while level=3 and vs_udr held high -> level=0, cmd_valid=0, all pulses 0; exactly one entry appears after the sync latency.
6. With DBG_CMD_TIMESTAMP_EN: two UDR pushes 10 clk apart -> cmd_ts values differ by 10; without the macro, cmd_ts=0.
